// File: rtl/sump_ctrl_pkg.sv
// rtl/sump_ctrl_pkg.sv - shared opcodes, field widths and FSM state for the SUMP command controller
package sump_ctrl_pkg;

    localparam int OPC_W = 8;
    localparam int ARG_W = 32;

    localparam logic [OPC_W-1:0] OP_RESET    = 8'h00;
    localparam logic [OPC_W-1:0] OP_ARM      = 8'h01;
    localparam logic [OPC_W-1:0] OP_ID       = 8'h02;
    localparam logic [OPC_W-1:0] OP_DIV      = 8'h80;
    localparam logic [OPC_W-1:0] OP_CNT      = 8'h81;
    localparam logic [OPC_W-1:0] OP_FLAGS    = 8'h82;
    // Stage opcodes carry the stage index in bits [3:2] on top of these bases
    localparam logic [OPC_W-1:0] OP_TRG_MASK = 8'hC0;
    localparam logic [OPC_W-1:0] OP_TRG_VAL  = 8'hC1;
    localparam logic [OPC_W-1:0] OP_TRG_CFG  = 8'hC2;

    localparam logic [31:0] ID_WORD_DEFAULT = 32'h534C4131;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_e;

endpackage

// File: rtl/sump_ctrl_if.sv
// rtl/sump_ctrl_if.sv - command input and transmitter byte handshake bundle
interface sump_ctrl_if;
    import sump_ctrl_pkg::*;

    logic [OPC_W+ARG_W-1:0] cmd_i;
    logic                   stb_i;
    logic [7:0]             tx_data_o;
    logic                   tx_stb_o;
    logic                   tx_ack_i;

    modport master (
        output cmd_i, stb_i, tx_ack_i,
        input  tx_data_o, tx_stb_o
    );

    modport slave (
        input  cmd_i, stb_i, tx_ack_i,
        output tx_data_o, tx_stb_o
    );

endinterface

// File: rtl/sump_id_tx.sv
// rtl/sump_id_tx.sv - sequences the 4-byte ID reply onto the transmitter handshake
module sump_id_tx
    import sump_ctrl_pkg::*;
#(
    parameter logic [31:0] ID_WORD = ID_WORD_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_in,
    input  logic       start,
    input  logic       abort,
    input  logic       tx_ack,
    output logic [7:0] tx_data,
    output logic       tx_stb
);

    tx_state_e  state_q, state_d;
    logic [1:0] idx_q, idx_d;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // A start while already sending is dropped, never queued
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEND;
                    idx_d   = 2'd0;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tx_ack) begin
                    if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_stb  = (state_q == ST_SEND);
    assign tx_data = tx_stb ? ID_WORD[{idx_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: rtl/sump_ctrl.sv
// rtl/sump_ctrl.sv - SUMP command decode, configuration registers and sampler pulses
module sump_ctrl
    import sump_ctrl_pkg::*;
#(
    parameter int          NUM_STAGES = 4,
    parameter logic [31:0] ID_WORD    = ID_WORD_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_in,
    sump_ctrl_if.slave              bus,
    output logic                    arm_o,
    output logic                    soft_rst_o,
    output logic [32*NUM_STAGES-1:0] trg_mask_o,
    output logic [32*NUM_STAGES-1:0] trg_val_o,
    output logic [32*NUM_STAGES-1:0] trg_cfg_o,
    output logic [23:0]             div_o,
    output logic [15:0]             read_cnt_o,
    output logic [15:0]             delay_cnt_o,
    output logic [31:0]             flags_o
);

    logic [OPC_W-1:0] opc;
    logic [ARG_W-1:0] arg;
    logic [1:0]       stage;
    logic [OPC_W-1:0] trg_base;
    logic             trg_hit;

    logic [NUM_STAGES-1:0][31:0] trg_mask_q, trg_val_q, trg_cfg_q;
    logic [23:0] div_q;
    logic [15:0] read_cnt_q, delay_cnt_q;
    logic [31:0] flags_q;
    logic        arm_q, soft_rst_q;

    assign opc      = bus.cmd_i[OPC_W-1:0];
    assign arg      = bus.cmd_i[OPC_W+ARG_W-1:OPC_W];
    assign stage    = opc[3:2];
    assign trg_base = {opc[7:4], 2'b00, opc[1:0]};
    // Only stage opcodes addressing an instantiated stage touch the trigger bank
    assign trg_hit  = bus.stb_i && (int'(stage) < NUM_STAGES) &&
                      ((trg_base == OP_TRG_MASK) || (trg_base == OP_TRG_VAL) ||
                       (trg_base == OP_TRG_CFG));

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            trg_mask_q  <= '0;
            trg_val_q   <= '0;
            trg_cfg_q   <= '0;
            div_q       <= '0;
            read_cnt_q  <= '0;
            delay_cnt_q <= '0;
            flags_q     <= '0;
            arm_q       <= 1'b0;
            soft_rst_q  <= 1'b0;
        end else begin
            arm_q      <= bus.stb_i && (opc == OP_ARM);
            soft_rst_q <= bus.stb_i && (opc == OP_RESET);
            if (bus.stb_i && opc == OP_DIV) begin
                div_q <= arg[23:0];
            end
            if (bus.stb_i && opc == OP_CNT) begin
                read_cnt_q  <= arg[15:0];
                delay_cnt_q <= arg[31:16];
            end
            if (bus.stb_i && opc == OP_FLAGS) begin
                flags_q <= arg;
            end
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (trg_hit && int'(stage) == s) begin
                    if (trg_base == OP_TRG_MASK) trg_mask_q[s] <= arg;
                    if (trg_base == OP_TRG_VAL)  trg_val_q[s]  <= arg;
                    if (trg_base == OP_TRG_CFG)  trg_cfg_q[s]  <= arg;
                end
            end
        end
    end

    sump_id_tx #(
        .ID_WORD (ID_WORD)
    ) u_id_tx (
        .clk_i   (clk_i),
        .rst_in  (rst_in),
        .start   (bus.stb_i && (opc == OP_ID)),
        .abort   (bus.stb_i && (opc == OP_RESET)),
        .tx_ack  (bus.tx_ack_i),
        .tx_data (bus.tx_data_o),
        .tx_stb  (bus.tx_stb_o)
    );

    assign arm_o       = arm_q;
    assign soft_rst_o  = soft_rst_q;
    assign trg_mask_o  = trg_mask_q;
    assign trg_val_o   = trg_val_q;
    assign trg_cfg_o   = trg_cfg_q;
    assign div_o       = div_q;
    assign read_cnt_o  = read_cnt_q;
    assign delay_cnt_o = delay_cnt_q;
    assign flags_o     = flags_q;

endmodule

// File: tb/tb_sump_ctrl.sv
// tb/tb_sump_ctrl.sv - self-checking bench for sump_ctrl with a two-stage trigger bank
module tb_sump_ctrl;

    localparam int NS = 2;

    logic clk_i;
    logic rst_in;

    sump_ctrl_if bus();

    logic          arm_o, soft_rst_o;
    logic [32*NS-1:0] trg_mask_o, trg_val_o, trg_cfg_o;
    logic [23:0]   div_o;
    logic [15:0]   read_cnt_o, delay_cnt_o;
    logic [31:0]   flags_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    sump_ctrl #(
        .NUM_STAGES (NS),
        .ID_WORD    (32'h534C4131)
    ) dut (
        .clk_i       (clk_i),
        .rst_in      (rst_in),
        .bus         (bus),
        .arm_o       (arm_o),
        .soft_rst_o  (soft_rst_o),
        .trg_mask_o  (trg_mask_o),
        .trg_val_o   (trg_val_o),
        .trg_cfg_o   (trg_cfg_o),
        .div_o       (div_o),
        .read_cnt_o  (read_cnt_o),
        .delay_cnt_o (delay_cnt_o),
        .flags_o     (flags_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic drive_cmd(input logic [7:0] opc, input logic [31:0] arg, input logic ack);
        bus.cmd_i    = {arg, opc};
        bus.stb_i    = 1'b1;
        bus.tx_ack_i = ack;
        @(posedge clk_i);
        #1;
        bus.stb_i    = 1'b0;
        bus.tx_ack_i = 1'b0;
    endtask

    task automatic push_id;
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h4C);
        exp_q.push_back(8'h53);
    endtask

    task automatic ack_byte(input int wait_cycles);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: no expected byte queued while tx_stb_o=%0b", bus.tx_stb_o);
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (bus.tx_stb_o !== 1'b1 || bus.tx_data_o !== exp) begin
            errors++;
            $display("FAIL tx_byte: stb=%0b data=%02h, required stb=1 data=%02h", bus.tx_stb_o, bus.tx_data_o, exp);
        end
        for (int k = 0; k < wait_cycles; k++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (bus.tx_stb_o !== 1'b1 || bus.tx_data_o !== exp) begin
                errors++;
                $display("FAIL tx_hold: stb=%0b data=%02h, required stb=1 data=%02h", bus.tx_stb_o, bus.tx_data_o, exp);
            end
        end
        bus.tx_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.tx_ack_i = 1'b0;
    endtask

    task automatic check_idle_tx(input string name);
        checks++;
        if (bus.tx_stb_o !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: tx_stb_o=%0b pending=%0d, required tx_stb_o=0 pending=0", name, bus.tx_stb_o, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_in       = 1'b0;
        bus.cmd_i    = '0;
        bus.stb_i    = 1'b0;
        bus.tx_ack_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({arm_o, soft_rst_o, bus.tx_stb_o, bus.tx_data_o, trg_mask_o, trg_val_o, trg_cfg_o,
             div_o, read_cnt_o, delay_cnt_o, flags_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero (div=%h flags=%h tx_stb=%0b), required all 0", div_o, flags_o, bus.tx_stb_o);
        end
        rst_in = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_div;
        drive_cmd(8'h80, 32'h0000_0180, 1'b0);
        checks++;
        if (div_o !== 24'h000180) begin
            errors++;
            $display("FAIL div: div_o=%h, required 000180", div_o);
        end
        checks++;
        if ({arm_o, soft_rst_o, bus.tx_stb_o, trg_mask_o, trg_val_o, trg_cfg_o, read_cnt_o, delay_cnt_o, flags_o} !== '0) begin
            errors++;
            $display("FAIL div_others: read_cnt=%h flags=%h arm=%0b, required all 0", read_cnt_o, flags_o, arm_o);
        end
    endtask

    task automatic test_trg;
        drive_cmd(8'hC4, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if (trg_mask_o !== 64'hDEADBEEF_00000000) begin
            errors++;
            $display("FAIL trg_mask_s1: trg_mask_o=%h, required deadbeef00000000", trg_mask_o);
        end
        drive_cmd(8'hC1, 32'h1111_2222, 1'b0);
        drive_cmd(8'hC6, 32'h3333_4444, 1'b0);
        checks++;
        if (trg_val_o !== 64'h00000000_11112222 || trg_cfg_o !== 64'h33334444_00000000) begin
            errors++;
            $display("FAIL trg_val_cfg: val=%h cfg=%h, required val=0000000011112222 cfg=3333444400000000", trg_val_o, trg_cfg_o);
        end
        drive_cmd(8'hCC, 32'h1234_5678, 1'b0);
        drive_cmd(8'hC9, 32'h1234_5678, 1'b0);
        checks++;
        if (trg_mask_o !== 64'hDEADBEEF_00000000 || trg_val_o !== 64'h00000000_11112222 || trg_cfg_o !== 64'h33334444_00000000) begin
            errors++;
            $display("FAIL trg_oob_stage: mask=%h val=%h cfg=%h changed by stage>=NUM_STAGES", trg_mask_o, trg_val_o, trg_cfg_o);
        end
    endtask

    task automatic test_cnt;
        drive_cmd(8'h81, 32'h0020_0010, 1'b0);
        checks++;
        if (read_cnt_o !== 16'h0010 || delay_cnt_o !== 16'h0020) begin
            errors++;
            $display("FAIL cnt: read_cnt=%h delay_cnt=%h, required 0010 0020", read_cnt_o, delay_cnt_o);
        end
    endtask

    task automatic test_ignored;
        logic [7:0] undef_ops [5] = '{8'h11, 8'h13, 8'h83, 8'hC3, 8'hFF};
        drive_cmd(8'h82, 32'hA5A5_0F0F, 1'b0);
        checks++;
        if (flags_o !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL flags: flags_o=%h, required a5a50f0f", flags_o);
        end
        foreach (undef_ops[i]) begin
            drive_cmd(undef_ops[i], 32'hFFFF_FFFF, 1'b0);
            checks++;
            if (div_o !== 24'h000180 || flags_o !== 32'hA5A5_0F0F || read_cnt_o !== 16'h0010 ||
                delay_cnt_o !== 16'h0020 || trg_mask_o !== 64'hDEADBEEF_00000000 ||
                arm_o !== 1'b0 || soft_rst_o !== 1'b0 || bus.tx_stb_o !== 1'b0) begin
                errors++;
                $display("FAIL ignored_op_%02h: div=%h flags=%h arm=%0b srst=%0b tx_stb=%0b, required no change", undef_ops[i], div_o, flags_o, arm_o, soft_rst_o, bus.tx_stb_o);
            end
        end
    endtask

    task automatic test_back_to_back;
        drive_cmd(8'h80, 32'h00AB_CDEF, 1'b0);
        drive_cmd(8'h82, 32'h0000_0007, 1'b0);
        checks++;
        if (div_o !== 24'hABCDEF || flags_o !== 32'h7) begin
            errors++;
            $display("FAIL b2b_regs: div=%h flags=%h, required abcdef 00000007", div_o, flags_o);
        end
        drive_cmd(8'h01, 32'h0, 1'b0);
        drive_cmd(8'h00, 32'h0, 1'b0);
        checks++;
        if (arm_o !== 1'b0 || soft_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pulses: arm=%0b srst=%0b, required 0 1", arm_o, soft_rst_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (soft_rst_o !== 1'b0 || div_o !== 24'hABCDEF) begin
            errors++;
            $display("FAIL b2b_srst_end: srst=%0b div=%h, required 0 abcdef", soft_rst_o, div_o);
        end
    endtask

    task automatic test_id;
        push_id();
        drive_cmd(8'h02, 32'h0, 1'b0);
        ack_byte(2);
        drive_cmd(8'h02, 32'h0, 1'b0);
        ack_byte(2);
        ack_byte(2);
        ack_byte(2);
        check_idle_tx("id_done");
        drive_cmd(8'h00, 32'h0, 1'b1);
        check_idle_tx("ack_in_idle");
    endtask

    task automatic test_abort;
        push_id();
        drive_cmd(8'h02, 32'h0, 1'b0);
        ack_byte(1);
        ack_byte(1);
        checks++;
        if (bus.tx_data_o !== 8'h4C) begin
            errors++;
            $display("FAIL abort_pre: tx_data_o=%02h, required 4c", bus.tx_data_o);
        end
        drive_cmd(8'h00, 32'h0, 1'b0);
        exp_q.delete();
        checks++;
        if (soft_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_srst: soft_rst_o=%0b, required 1", soft_rst_o);
        end
        check_idle_tx("abort_stb");
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (soft_rst_o !== 1'b0 || bus.tx_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: srst=%0b tx_stb=%0b, required 0 0", soft_rst_o, bus.tx_stb_o);
        end
        push_id();
        drive_cmd(8'h02, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) ack_byte(0);
        check_idle_tx("restart_done");
    endtask

    task automatic test_arm_ack;
        push_id();
        drive_cmd(8'h02, 32'h0, 1'b0);
        ack_byte(1);
        checks++;
        if (bus.tx_data_o !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL arm_pre: tx_data_o=%02h, required 41", bus.tx_data_o);
        end
        drive_cmd(8'h01, 32'h0, 1'b1);
        checks++;
        if (arm_o !== 1'b1 || bus.tx_stb_o !== 1'b1 || bus.tx_data_o !== exp_q[0]) begin
            errors++;
            $display("FAIL arm_with_ack: arm=%0b stb=%0b data=%02h, required 1 1 %02h", arm_o, bus.tx_stb_o, bus.tx_data_o, exp_q[0]);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (arm_o !== 1'b0) begin
            errors++;
            $display("FAIL arm_width: arm_o=%0b, required 0", arm_o);
        end
        ack_byte(0);
        ack_byte(0);
        check_idle_tx("arm_ack_done");
        push_id();
        drive_cmd(8'h02, 32'h0, 1'b0);
        drive_cmd(8'h00, 32'h0, 1'b1);
        exp_q.delete();
        checks++;
        if (soft_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_ack_srst: soft_rst_o=%0b, required 1", soft_rst_o);
        end
        check_idle_tx("abort_wins");
    endtask

    task automatic test_reset_mid;
        push_id();
        drive_cmd(8'h02, 32'h0, 1'b0);
        ack_byte(0);
        rst_in = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({arm_o, soft_rst_o, bus.tx_stb_o, bus.tx_data_o, trg_mask_o, trg_val_o, trg_cfg_o,
             div_o, read_cnt_o, delay_cnt_o, flags_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid: tx_stb=%0b data=%02h div=%h flags=%h, required all 0", bus.tx_stb_o, bus.tx_data_o, div_o, flags_o);
        end
        @(posedge clk_i);
        #1;
        rst_in = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_idle_tx("reset_release");
    endtask

    initial begin
        test_reset();
        test_div();
        test_trg();
        test_cnt();
        test_ignored();
        test_back_to_back();
        test_id();
        test_abort();
        test_arm_ack();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
